// File: rtl/tcdm_bank_responder_pkg.sv
// Shared TCDM types for the bank responder and its response queue.
package tcdm_bank_responder_pkg;

    localparam int unsigned AddrWidth = 10;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned BeWidth   = DataWidth / 8;

    typedef logic [AddrWidth-1:0] tcdm_addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [BeWidth-1:0]   be_t;

    // Pointer width for an n-entry ring; a single entry still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_responder_fifo.sv
// Fall-through response queue: an empty queue forwards a push in the same cycle.
module tcdm_bank_responder_fifo
    import tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       valid_o,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned UsgW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [UsgW-1:0]  usage_q;
    logic             empty, wr_en, rd_en;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (usage_q == '0);
    assign full_o  = (usage_q == UsgW'(Depth));
    assign usage_o = usage_q;
    // A push into an empty queue that is popped in the same cycle bypasses storage.
    assign wr_en   = push_i & ~full_o & ~(empty & pop_i);
    assign rd_en   = pop_i & ~empty;
    assign valid_o = ~empty | push_i;
    assign data_o  = ~empty ? mem_q[rd_ptr_q] : (push_i ? data_i : '0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (rd_en) rd_ptr_q <= next_ptr(rd_ptr_q);
            usage_q <= usage_q + UsgW'(wr_en) - UsgW'(rd_en);
        end
    end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM slave responder: credit-gated grant, fixed-latency bank pipe and an
// in-order response queue that echoes requester metadata.
module tcdm_bank_responder
    import tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned NumOutstanding = 2,
    parameter int unsigned BankLatency    = 1,
    parameter int unsigned MetaWidth      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tcdm_req_i,
    input  tcdm_addr_t           tcdm_addr_i,
    input  logic                 tcdm_wen_i,
    input  data_t                tcdm_wdata_i,
    input  be_t                  tcdm_be_i,
    input  logic [MetaWidth-1:0] tcdm_meta_i,
    output logic                 tcdm_gnt_o,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output data_t                resp_rdata_o,
    output logic                 resp_wen_o,
    output logic [MetaWidth-1:0] resp_meta_o,
    output logic                 mem_req_o,
    output tcdm_addr_t           mem_addr_o,
    output logic                 mem_wen_o,
    output data_t                mem_wdata_o,
    output be_t                  mem_be_o,
    input  data_t                mem_rdata_i
);

    localparam int unsigned CntW  = $clog2(NumOutstanding + 1);
    localparam int unsigned RespW = DataWidth + 1 + MetaWidth;
    localparam logic [CntW-1:0] MaxCnt = CntW'(NumOutstanding);

    logic [CntW-1:0] cnt_q;
    logic            handshake, push, fifo_full;
    logic [CntW-1:0] usage;
    logic [RespW-1:0] push_data, pop_data;

    // Stage 0 is the grant cycle itself; stages 1..BankLatency are registered.
    logic [BankLatency-1:0]                vld_q, wen_q;
    logic [BankLatency-1:0][MetaWidth-1:0] meta_q;
    logic [BankLatency:0]                  vld_pipe, wen_pipe;
    logic [BankLatency:0][MetaWidth-1:0]   meta_pipe;

    assign handshake = resp_valid_o & resp_ready_i;
    // A response leaving this cycle frees its credit for a same-cycle grant.
    assign tcdm_gnt_o = rst_ni & tcdm_req_i & ((cnt_q < MaxCnt) | handshake);

    assign mem_req_o   = tcdm_gnt_o;
    assign mem_addr_o  = tcdm_addr_i;
    assign mem_wen_o   = tcdm_wen_i;
    assign mem_wdata_o = tcdm_wdata_i;
    assign mem_be_o    = tcdm_be_i;

    assign vld_pipe  = {vld_q, tcdm_gnt_o};
    assign wen_pipe  = {wen_q, tcdm_wen_i};
    assign meta_pipe = {meta_q, tcdm_meta_i};

    // Bank pipe tracks each granted access until its read data is due; never stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            wen_q  <= '0;
            meta_q <= '0;
        end else begin
            vld_q  <= vld_pipe[BankLatency-1:0];
            wen_q  <= wen_pipe[BankLatency-1:0];
            meta_q <= meta_pipe[BankLatency-1:0];
        end
    end

    assign push      = vld_pipe[BankLatency];
    assign push_data = {wen_pipe[BankLatency] ? '0 : mem_rdata_i,
                        wen_pipe[BankLatency], meta_pipe[BankLatency]};

    tcdm_bank_responder_fifo #(
        .Depth (NumOutstanding),
        .Width (RespW)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (handshake),
        .full_o  (fifo_full),
        .valid_o (resp_valid_o),
        .data_o  (pop_data),
        .usage_o (usage)
    );

    assign {resp_rdata_o, resp_wen_o, resp_meta_o} = pop_data;

    // Credits: one per granted request until its response is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            case ({tcdm_gnt_o, handshake})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= MaxCnt);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full));
    a_resp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        resp_valid_o && !resp_ready_i |=>
        resp_valid_o && $stable({resp_rdata_o, resp_wen_o, resp_meta_o}));
    a_credit_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(cnt_q) == int'($countones(vld_q)) + int'(usage));
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus random traffic, all
// checked against a transaction-level queue model of the responder.
module tb_tcdm_bank_responder;
    import tcdm_bank_responder_pkg::*;

    localparam int N = 2;
    localparam int L = 1;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       tcdm_req_i, tcdm_wen_i, resp_ready_i;
    tcdm_addr_t tcdm_addr_i;
    data_t      tcdm_wdata_i;
    be_t        tcdm_be_i;
    logic [7:0] tcdm_meta_i;
    logic       tcdm_gnt_o, resp_valid_o, resp_wen_o;
    data_t      resp_rdata_o;
    logic [7:0] resp_meta_o;
    logic       mem_req_o, mem_wen_o;
    tcdm_addr_t mem_addr_o;
    data_t      mem_wdata_o, mem_rdata_i;
    be_t        mem_be_o;

    tcdm_bank_responder #(.NumOutstanding(N), .BankLatency(L), .MetaWidth(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .tcdm_req_i(tcdm_req_i), .tcdm_addr_i(tcdm_addr_i), .tcdm_wen_i(tcdm_wen_i),
        .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i), .tcdm_meta_i(tcdm_meta_i),
        .tcdm_gnt_o(tcdm_gnt_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_wen_o(resp_wen_o), .resp_meta_o(resp_meta_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Bank: single-cycle SRAM written through the DUT's mem_* outputs; idle
    // and write cycles return noise so a leaked read value is visible.
    data_t bank_mem [1024];
    always @(posedge clk) begin
        if (mem_req_o && !mem_wen_o) begin
            mem_rdata_i <= bank_mem[mem_addr_o];
        end else begin
            mem_rdata_i <= $urandom();
            if (mem_req_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) bank_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    // Reference: expected memory contents and the ordered list of owed responses.
    typedef struct {
        logic [31:0] d;
        logic        w;
        logic [7:0]  m;
        int          due;
    } exp_t;
    exp_t  q[$];
    data_t ref_mem [1024];
    int    cyc = 0;
    int    n_cmp = 0, n_bad = 0;
    int    n_gnt_obs = 0, n_resp = 0;
    logic  eg, ev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with reset released: drive, check against the model, advance the model.
    task automatic step(input logic rq, input logic wn, input logic [9:0] ad,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [7:0] mt, input logic rdy);
        exp_t e;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        tcdm_req_i = rq; tcdm_wen_i = wn; tcdm_addr_i = ad; tcdm_wdata_i = wd;
        tcdm_be_i = be; tcdm_meta_i = mt; resp_ready_i = rdy;
        #3;
        ev = (q.size() > 0) && (q[0].due <= cyc);
        eg = rq && ((q.size() < N) || (ev && rdy));
        chk("resp_valid", 64'(resp_valid_o), 64'(ev));
        if (ev) begin
            chk("resp_rdata", 64'(resp_rdata_o), 64'(q[0].d));
            chk("resp_wen",   64'(resp_wen_o),   64'(q[0].w));
            chk("resp_meta",  64'(resp_meta_o),  64'(q[0].m));
        end
        chk("gnt", 64'(tcdm_gnt_o), 64'(eg));
        chk("mem_req", 64'(mem_req_o), 64'(eg));
        if (eg) begin
            chk("mem_fields", {mem_wen_o, mem_be_o, mem_addr_o, mem_wdata_o},
                              {wn, be, ad, wd});
        end
        if (tcdm_gnt_o) n_gnt_obs++;
        if (ev && rdy) begin
            void'(q.pop_front());
            n_resp++;
        end
        if (eg) begin
            e.d = wn ? 32'h0 : ref_mem[ad];
            e.w = wn; e.m = mt; e.due = cyc + L;
            q.push_back(e);
            if (wn) for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[ad][8*b +: 8] = wd[8*b +: 8];
        end
        cyc++;
    endtask

    // Reset cycles with a request asserted: everything must stay quiet.
    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst_ni = 1'b0; tcdm_req_i = 1'b1; resp_ready_i = 1'b1;
            #3;
            chk("rst_gnt",        64'(tcdm_gnt_o),   64'(0));
            chk("rst_mem_req",    64'(mem_req_o),    64'(0));
            chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
            chk("rst_resp_rdata", 64'(resp_rdata_o), 64'(0));
            q.delete();
            cyc++;
        end
    endtask

    int          k, g0;
    logic        pend, pw;
    logic [9:0]  pa;
    logic [31:0] pd;
    logic [3:0]  pb;
    logic [7:0]  pm;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bank_mem[i] = $urandom();
            ref_mem[i]  = bank_mem[i];
        end
        bank_mem[16] = 32'hDEADBEEF;
        ref_mem[16]  = 32'hDEADBEEF;
        rst_ni = 1'b0; tcdm_req_i = 1'b1; tcdm_wen_i = 1'b0; tcdm_addr_i = '0;
        tcdm_wdata_i = '0; tcdm_be_i = '0; tcdm_meta_i = '0; resp_ready_i = 1'b0;

        // Reset with a request pending.
        rst_cycles(3);

        // Single read, then single write; responses one cycle later.
        step(1, 0, 10'h10, 0, 4'hF, 8'h2A, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("read_resp_count", 64'(n_resp), 64'(1));
        step(1, 1, 10'h20, 32'h12345678, 4'hF, 8'h05, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 10'h20, 0, 4'hF, 8'h06, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Back-pressure: four reads, only two credits while ready is low.
        k = 0; g0 = n_gnt_obs;
        for (int c = 0; c < 12; c++) begin
            step(k < 4, 0, 10'(k), 0, 4'hF, 8'(k), c >= 5);
            if (c == 4) chk("bp_grants_held", 64'(n_gnt_obs - g0), 64'(2));
            if (eg) k++;
        end
        chk("bp_grants_total", 64'(n_gnt_obs - g0), 64'(4));

        // Streaming: 100 reads back-to-back with ready held high.
        g0 = n_gnt_obs; k = n_resp;
        for (int i = 0; i < 100; i++) step(1, 0, 10'($urandom_range(0, 31)), 0, 4'hF, 8'(i), 1);
        chk("stream_grants", 64'(n_gnt_obs - g0), 64'(100));
        step(0, 0, 0, 0, 0, 0, 1);
        chk("stream_resps", 64'(n_resp - k), 64'(100));

        // Reset while two reads are in flight; nothing may surface afterwards.
        step(1, 0, 10'h3, 0, 4'hF, 8'h60, 0);
        step(1, 0, 10'h4, 0, 4'hF, 8'h61, 0);
        rst_cycles(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
        // Fresh credits: two grants without any handshake, third refused.
        for (int i = 0; i < 3; i++) step(1, 0, 10'h10, 0, 4'hF, 8'(8'h70 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Random mixed traffic; the requester holds each request until granted.
        pend = 0; pw = 0; pa = 0; pd = 0; pb = 0; pm = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1;
                pw = 1'($urandom_range(0, 1));
                pa = 10'($urandom_range(0, 15));
                pd = $urandom();
                pb = 4'($urandom_range(0, 15));
                pm = 8'($urandom());
            end
            step(pend, pw, pa, pd, pb, pm, $urandom_range(0, 9) < 7);
            if (eg) pend = 0;
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
